// File: rtl/mpsoc_dbg_pkg.sv
// Shared constants for the debug unit's toggle-handshake clock-domain crossing.
// Holds the default data width and synchronizer depth used by the handshake
// endpoints, plus the receive buffer depth and its occupancy counter width.
package mpsoc_dbg_pkg;

  localparam int DW_DEFAULT          = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int FIFO_DEPTH          = 2;
  localparam int LEVEL_W             = 2;

endpackage

// File: rtl/mpsoc_dbg_sync_chain.sv
// N-stage single-bit synchronizer for a level/toggle signal crossing into the
// clk domain. Also used by the sender endpoint on its acknowledge path.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, all stages clear to 0
//   d     - asynchronous input
//   q     - synchronized output (last stage)
module mpsoc_dbg_sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/mpsoc_dbg_hs_rx.sv
// Receiving endpoint of the toggle-handshake CDC. Synchronizes the sender's
// request toggle, captures the stable data word when buffer space exists,
// returns an acknowledge toggle, and presents words through a 2-entry
// valid/ready buffer.
// Ports:
//   CLK            - receiving-domain clock
//   RSTN           - asynchronous active-low reset
//   REQ_TOGGLE_IN  - request toggle from the sender (asynchronous)
//   DATA_IN        - sender data, stable while a request is outstanding
//   ACK_TOGGLE_OUT - registered acknowledge toggle back to the sender
//   DATA_OUT       - head-of-buffer word
//   VALID_OUT      - buffer non-empty
//   READY_IN       - consumer accepts DATA_OUT when VALID_OUT & READY_IN
//   LEVEL_OUT      - buffer occupancy 0..2
module mpsoc_dbg_hs_rx
  import mpsoc_dbg_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               REQ_TOGGLE_IN,
  input  logic [DW-1:0]      DATA_IN,
  output logic               ACK_TOGGLE_OUT,
  output logic [DW-1:0]      DATA_OUT,
  output logic               VALID_OUT,
  input  logic               READY_IN,
  output logic [LEVEL_W-1:0] LEVEL_OUT
);

  logic               req_s;
  logic               ack;
  logic               pending;
  logic               pop;
  logic               space;
  logic               push;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic [LEVEL_W-1:0] count_next;
  logic [DW-1:0]      entry [FIFO_DEPTH];

  mpsoc_dbg_sync_chain #(
    .N (SYNC_STAGES)
  ) u_req_sync (
    .clk   (CLK),
    .rst_n (RSTN),
    .d     (REQ_TOGGLE_IN),
    .q     (req_s)
  );

  // Handshake decode: a request is outstanding while the synchronized toggle
  // differs from our ack; it is taken only when a slot is free or one is
  // being freed on this same edge (so a full buffer never stalls a pop+push).
  always_comb begin
    pending = 1'b0;
    pop     = 1'b0;
    space   = 1'b0;
    push    = 1'b0;
    pending = req_s ^ ack;
    pop     = (count != {LEVEL_W{1'b0}}) & READY_IN;
    space   = (count < LEVEL_W'(FIFO_DEPTH)) | pop;
    push    = pending & space;
  end

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + {{(LEVEL_W-1){1'b0}}, 1'b1};
      2'b01:   count_next = count - {{(LEVEL_W-1){1'b0}}, 1'b1};
      default: count_next = count;
    endcase
  end

  // Buffer storage, pointers, occupancy and ack toggle. DATA_IN is sampled
  // only on capture edges, when the sender guarantees it is stable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ack    <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else begin
      if (push) begin
        entry[wr_ptr] <= DATA_IN;
        wr_ptr        <= wr_ptr + 1'b1;
        ack           <= ~ack;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  assign ACK_TOGGLE_OUT = ack;
  assign DATA_OUT       = entry[rd_ptr];
  assign VALID_OUT      = (count != {LEVEL_W{1'b0}});
  assign LEVEL_OUT      = count;

endmodule
